// File: rtl/o_serdes_tx_if.sv
// Fabric-side word handshake for o_serdes_tx.
// Signals:
//   D        parallel word (WIDTH bits)
//   D_OE     output-enable qualifier travelling with D
//   D_VALID  D/D_OE valid this cycle
//   D_READY  serializer can take a word this cycle
// Modports: master = fabric producer, slave = serializer.
interface o_serdes_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             D_OE;
  logic             D_VALID;
  logic             D_READY;

  modport master (output D, output D_OE, output D_VALID, input D_READY);
  modport slave  (input D, input D_OE, input D_VALID, output D_READY);
endinterface

// File: rtl/o_serdes_tx.sv
// Parallel-to-serial output stage feeding an O_BUFT cell (Q -> I, T -> T).
// Words arrive over a valid/ready handshake into a one-word holding
// register, then shift out one bit per CLK. Back-to-back words stream
// without gap bits because the holding register refills the shifter on
// the same edge the previous word's last bit is retired.
// Ports:
//   CLK   serial-rate clock, rising edge
//   RST   asynchronous active-high reset
//   fab   word handshake (D, D_OE, D_VALID in; D_READY out)
//   Q     serial data to O_BUFT I
//   T     pad drive enable to O_BUFT T (1 = drive)
//   BUSY  a word sits in the shifter or the holding register
//
// state | meaning
// IDLE  | shifter empty, Q = IDLE_VALUE, T = 0
// SHIFT | a word is on Q, bit_cnt = index of bit currently shown
module o_serdes_tx #(
  parameter int   WIDTH      = 4,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  o_serdes_tx_if.slave  fab,
  output logic          Q,
  output logic          T,
  output logic          BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_oe;
  logic             hold_full;
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             busy;
  logic             last_bit;
  logic             load;
  logic             accept;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load) state_nxt = SHIFT;
      SHIFT: if (!load && last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy        = (state == SHIFT);
    last_bit    = busy && (bit_cnt == LAST);
    // Refill the shifter when it is empty or about to retire its last bit.
    load        = hold_full && (!busy || (bit_cnt == LAST));
    // Ready only looks at registered state, so it never depends on D_VALID.
    fab.D_READY = !RST && (!hold_full || load);
    accept      = fab.D_VALID && fab.D_READY;
    BUSY        = busy || hold_full;
  end

  // Holding register and shifter datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_data <= '0;
      hold_oe   <= 1'b0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      Q         <= IDLE_VALUE;
      T         <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= fab.D;
        hold_oe   <= fab.D_OE;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        T       <= hold_oe;
        bit_cnt <= '0;
        if (LSB_FIRST) begin
          Q     <= hold_data[0];
          shreg <= hold_data[WIDTH-1:1];
        end else begin
          Q     <= hold_data[WIDTH-1];
          shreg <= hold_data[WIDTH-2:0];
        end
      end else if (busy) begin
        if (last_bit) begin
          Q       <= IDLE_VALUE;
          T       <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          if (LSB_FIRST) begin
            Q     <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
            Q     <= shreg[WIDTH-2];
            shreg <= shreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_o_serdes_tx.sv
module tb_o_serdes_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  o_serdes_tx_if #(.WIDTH(4)) ifa ();
  o_serdes_tx_if #(.WIDTH(4)) ifb ();

  logic q_a, t_a, busy_a;
  logic q_b, t_b, busy_b;

  o_serdes_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_VALUE(1'b0)) u_a (
    .CLK(clk), .RST(rst), .fab(ifa.slave), .Q(q_a), .T(t_a), .BUSY(busy_a)
  );

  o_serdes_tx #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_VALUE(1'b1)) u_b (
    .CLK(clk), .RST(rst), .fab(ifb.slave), .Q(q_b), .T(t_b), .BUSY(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_seq bit i = value expected on Q on the i-th bit cycle
  typedef struct {
    logic [3:0] d;
    logic       oe;
    logic [3:0] exp_seq;
  } vec_t;

  vec_t vecs[4];

  logic [3:0]  bp_words[4];
  int          acc_cyc[4];
  int          exp_acc[4];
  logic [15:0] stream, exp_stream;
  int          n;

  initial begin
    vecs[0] = '{4'b1011, 1'b1, 4'b1011};  // Q = 1,1,0,1
    vecs[1] = '{4'hF,    1'b0, 4'b1111};  // D_OE=0: Q = 1,1,1,1, T stays 0
    vecs[2] = '{4'h6,    1'b1, 4'b0110};  // Q = 0,1,1,0
    vecs[3] = '{4'h8,    1'b1, 4'b1000};  // Q = 0,0,0,1

    ifa.D = '0; ifa.D_OE = 1'b0; ifa.D_VALID = 1'b0;
    ifb.D = '0; ifb.D_OE = 1'b0; ifb.D_VALID = 1'b0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    #2;
    check("rst_ready", ifa.D_READY, 1'b0);
    check("rst_q",     q_a, 1'b0);
    check("rst_t",     t_a, 1'b0);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_q_b",   q_b, 1'b1);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rel_ready", ifa.D_READY, 1'b1);
    tick();

    // ---------------- table-driven single words ----------------
    for (int v = 0; v < 4; v++) begin
      ifa.D = vecs[v].d; ifa.D_OE = vecs[v].oe; ifa.D_VALID = 1'b1;
      tick();                       // edge k: accepted
      ifa.D_VALID = 1'b0;
      check("vec_busy_held", busy_a, 1'b1);
      check("vec_t_pre", t_a, 1'b0);
      for (int i = 0; i < 4; i++) begin
        tick();                     // edges k+1 .. k+4
        check($sformatf("vec%0d_q%0d", v, i), q_a, vecs[v].exp_seq[i]);
        check($sformatf("vec%0d_t%0d", v, i), t_a, vecs[v].oe);
      end
      tick();
      check("vec_end_q", q_a, 1'b0);
      check("vec_end_t", t_a, 1'b0);
      check("vec_end_busy", busy_a, 1'b0);
    end

    // ---------------- back-to-back 4'hA then 4'h5 ----------------
    begin
      logic [7:0] exp_q;
      logic [7:0] exp_rdy;
      exp_q   = 8'b01011010;   // bit i = Q on cycle i: 0,1,0,1,1,0,1,0
      exp_rdy = 8'b11111000;   // ready low only on cycles 0..2
      ifa.D = 4'hA; ifa.D_OE = 1'b1; ifa.D_VALID = 1'b1;
      tick();
      check("b2b_ready_load", ifa.D_READY, 1'b1);
      ifa.D = 4'h5;
      tick();
      ifa.D_VALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i > 0) tick();
        check($sformatf("b2b_q%0d", i), q_a, exp_q[i]);
        check($sformatf("b2b_t%0d", i), t_a, 1'b1);
        check($sformatf("b2b_rdy%0d", i), ifa.D_READY, exp_rdy[i]);
      end
      tick();
      check("b2b_end_q", q_a, 1'b0);
      check("b2b_end_busy", busy_a, 1'b0);
      tick();
    end

    // ---------------- backpressure with scoreboard ----------------
    bp_words[0] = 4'h9; bp_words[1] = 4'hC; bp_words[2] = 4'h3; bp_words[3] = 4'hE;
    exp_acc[0] = 0; exp_acc[1] = 1; exp_acc[2] = 5; exp_acc[3] = 9;
    for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
    n = 0;
    stream = '0;
    ifa.D_OE = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (n < 4) begin
        ifa.D = bp_words[n];
        ifa.D_VALID = 1'b1;
      end else begin
        ifa.D_VALID = 1'b0;
      end
      if (c >= 2 && c <= 17) stream[c-2] = q_a;
      if (c == 18) check("bp_idle_busy", busy_a, 1'b0);
      if (ifa.D_VALID && ifa.D_READY) begin
        acc_cyc[n] = c;
        n++;
      end
      tick();
    end
    ifa.D_VALID = 1'b0;
    check("bp_count", n, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_acc%0d", i), acc_cyc[i], exp_acc[i]);
    exp_stream = {bp_words[3], bp_words[2], bp_words[1], bp_words[0]};
    check("bp_stream", stream, exp_stream);

    // ---------------- MSB-first, IDLE_VALUE=1 instance ----------------
    check("msb_pre_q", q_b, 1'b1);
    check("msb_pre_t", t_b, 1'b0);
    ifb.D = 4'b1000; ifb.D_OE = 1'b1; ifb.D_VALID = 1'b1;
    tick();
    ifb.D_VALID = 1'b0;
    check("msb_acc_q", q_b, 1'b1);
    check("msb_acc_t", t_b, 1'b0);
    begin
      logic [3:0] exp_b;
      exp_b = 4'b0001;  // bit i = Q on cycle i: 1,0,0,0
      for (int i = 0; i < 4; i++) begin
        tick();
        check($sformatf("msb_q%0d", i), q_b, exp_b[i]);
        check($sformatf("msb_t%0d", i), t_b, 1'b1);
      end
    end
    tick();
    check("msb_post_q", q_b, 1'b1);
    check("msb_post_t", t_b, 1'b0);
    check("msb_post_busy", busy_b, 1'b0);

    // ---------------- async reset mid-word with held word ----------------
    ifa.D = 4'h6; ifa.D_OE = 1'b1; ifa.D_VALID = 1'b1;
    tick();
    ifa.D = 4'h9;
    tick();                         // 4'h6 loaded, 4'h9 held
    ifa.D_VALID = 1'b0;
    check("mrst_q0", q_a, 1'b0);
    tick();
    check("mrst_q1", q_a, 1'b1);
    tick();
    check("mrst_q2", q_a, 1'b1);
    check("mrst_busy_pre", busy_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_q_now", q_a, 1'b0);
    check("mrst_t_now", t_a, 1'b0);
    check("mrst_busy_now", busy_a, 1'b0);
    check("mrst_ready_now", ifa.D_READY, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_rel_ready", ifa.D_READY, 1'b1);
    check("mrst_rel_q", q_a, 1'b0);
    check("mrst_rel_t", t_a, 1'b0);
    tick();
    check("mrst_no_old", busy_a, 1'b0);
    ifa.D = 4'h3; ifa.D_OE = 1'b1; ifa.D_VALID = 1'b1;
    tick();
    ifa.D_VALID = 1'b0;
    begin
      logic [3:0] exp_3;
      exp_3 = 4'b0011;  // Q = 1,1,0,0
      for (int i = 0; i < 4; i++) begin
        tick();
        check($sformatf("mrst_new_q%0d", i), q_a, exp_3[i]);
        check($sformatf("mrst_new_t%0d", i), t_a, 1'b1);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mrst_tail_q%0d", i), q_a, 1'b0);
      check($sformatf("mrst_tail_busy%0d", i), busy_a, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
